// File: rtl/shift_unit_pipe.sv
// rtl/shift_unit_pipe.sv - pipelined shift/rotate unit with carry, zero and illegal-op flags
// Coarse shift in stage 1 and fine shift in stage 2 when PIPE_STAGES=2; a single combinational shift otherwise.
module shift_unit_pipe #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_W     = $clog2(WIDTH),
  parameter int PIPE_STAGES = 2
) (
  input  logic               clk2,
  input  logic               rst2,
  input  logic               en_sh,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         shift_op,
  input  logic [SHAMT_W-1:0] shift_nos,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   aluout_sh,
  output logic               carry,
  output logic               zero,
  output logic               op_err
);

  localparam int FINE_W = SHAMT_W / 2;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SLA = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  function automatic logic is_illegal(input logic [2:0] op);
    is_illegal = op[2] & op[1];
  endfunction

  // sign is passed explicitly so the fine stage can keep filling with the original MSB
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [2:0] op,
                                                input logic [SHAMT_W-1:0] a,
                                                input logic sign);
    logic [2*WIDTH-1:0] wide;
    wide     = '0;
    shift_by = d;
    case (op)
      OP_SLL, OP_SLA: shift_by = d << a;
      OP_SRL:         shift_by = d >> a;
      OP_SRA: begin
        wide     = {{WIDTH{sign}}, d} >> a;
        shift_by = wide[WIDTH-1:0];
      end
      OP_ROL: begin
        wide     = {d, d} << a;
        shift_by = wide[2*WIDTH-1:WIDTH];
      end
      OP_ROR: begin
        wide     = {d, d} >> a;
        shift_by = wide[WIDTH-1:0];
      end
      default: shift_by = d;
    endcase
  endfunction

  // WIDTH is a power of two, so 0-n wraps to WIDTH-n
  function automatic logic carry_of(input logic [WIDTH-1:0] d,
                                    input logic [2:0] op,
                                    input logic [SHAMT_W-1:0] n);
    logic [SHAMT_W-1:0] idx_l;
    logic [SHAMT_W-1:0] idx_r;
    idx_l    = {SHAMT_W{1'b0}} - n;
    idx_r    = n - {{(SHAMT_W-1){1'b0}}, 1'b1};
    carry_of = 1'b0;
    if (n != '0) begin
      case (op)
        OP_SLL, OP_SLA, OP_ROL: carry_of = d[idx_l];
        OP_SRL, OP_SRA, OP_ROR: carry_of = d[idx_r];
        default:                carry_of = 1'b0;
      endcase
    end
  endfunction

  logic             adv_out;
  logic             feed_valid;
  logic [WIDTH-1:0] feed_data;
  logic             feed_carry;
  logic             feed_err;

  assign adv_out = en_sh && (!out_valid || out_ready);

  generate
    if (PIPE_STAGES == 1) begin : g_one
      assign in_ready   = adv_out;
      assign feed_valid = in_valid;
      assign feed_data  = shift_by(in_data, shift_op, shift_nos, in_data[WIDTH-1]);
      assign feed_carry = carry_of(in_data, shift_op, shift_nos);
      assign feed_err   = is_illegal(shift_op);
    end else begin : g_two
      logic               s1_valid;
      logic [WIDTH-1:0]   s1_data;
      logic [2:0]         s1_op;
      logic [SHAMT_W-1:0] s1_fine;
      logic               s1_sign;
      logic               s1_carry;
      logic               s1_err;
      logic               adv_s1;
      logic [SHAMT_W-1:0] coarse_amt;
      logic [SHAMT_W-1:0] fine_amt;

      assign adv_s1     = en_sh && (!s1_valid || adv_out);
      assign in_ready   = adv_s1;
      assign coarse_amt = {shift_nos[SHAMT_W-1:FINE_W], {FINE_W{1'b0}}};
      assign fine_amt   = {{(SHAMT_W-FINE_W){1'b0}}, shift_nos[FINE_W-1:0]};

      always_ff @(posedge clk2) begin
        if (rst2) begin
          s1_valid <= 1'b0;
          s1_data  <= '0;
          s1_op    <= '0;
          s1_fine  <= '0;
          s1_sign  <= 1'b0;
          s1_carry <= 1'b0;
          s1_err   <= 1'b0;
        end else if (adv_s1) begin
          s1_valid <= in_valid;
          if (in_valid) begin
            s1_data  <= shift_by(in_data, shift_op, coarse_amt, in_data[WIDTH-1]);
            s1_op    <= shift_op;
            s1_fine  <= fine_amt;
            s1_sign  <= in_data[WIDTH-1];
            s1_carry <= carry_of(in_data, shift_op, shift_nos);
            s1_err   <= is_illegal(shift_op);
          end
        end
      end

      assign feed_valid = s1_valid;
      assign feed_data  = shift_by(s1_data, s1_op, s1_fine, s1_sign);
      assign feed_carry = s1_carry;
      assign feed_err   = s1_err;
    end
  endgenerate

  // outputs only reload when new data arrives, so a drained slot keeps its last values
  always_ff @(posedge clk2) begin
    if (rst2) begin
      out_valid <= 1'b0;
      aluout_sh <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      op_err    <= 1'b0;
    end else if (adv_out) begin
      out_valid <= feed_valid;
      if (feed_valid) begin
        aluout_sh <= feed_data;
        carry     <= feed_carry;
        zero      <= (feed_data == '0);
        op_err    <= feed_err;
      end
    end
  end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb/tb_shift_unit_pipe.sv - directed vector bench for shift_unit_pipe
// Drives 32-bit 2-stage/1-stage and 16-bit 2-stage instances.
module tb_shift_unit_pipe;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  n;
    logic [31:0] din;
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        e;
  } vec_t;

  logic        clk2 = 1'b0;
  logic        rst2 = 1'b1;
  logic        en_sh = 1'b1;
  logic        out_ready = 1'b0;
  logic [2:0]  shift_op = 3'b000;
  logic        iv32 = 1'b0;
  logic [31:0] d32 = '0;
  logic [4:0]  n32 = '0;
  logic        iv16 = 1'b0;
  logic [15:0] d16 = '0;
  logic [3:0]  n16 = '0;

  logic        a_in_ready, a_out_valid, a_carry, a_zero, a_op_err;
  logic [31:0] a_aluout;
  logic        b_in_ready, b_out_valid, b_carry, b_zero, b_op_err;
  logic [31:0] b_aluout;
  logic        c_in_ready, c_out_valid, c_carry, c_zero, c_op_err;
  logic [15:0] c_aluout;

  int checks = 0;
  int errors = 0;

  vec_t v32[19];
  vec_t v16[10];

  shift_unit_pipe #(.WIDTH(32), .PIPE_STAGES(2)) u_a (
    .clk2(clk2), .rst2(rst2), .en_sh(en_sh), .in_valid(iv32), .in_ready(a_in_ready),
    .in_data(d32), .shift_op(shift_op), .shift_nos(n32), .out_valid(a_out_valid),
    .out_ready(out_ready), .aluout_sh(a_aluout), .carry(a_carry), .zero(a_zero), .op_err(a_op_err)
  );

  shift_unit_pipe #(.WIDTH(32), .PIPE_STAGES(1)) u_b (
    .clk2(clk2), .rst2(rst2), .en_sh(en_sh), .in_valid(iv32), .in_ready(b_in_ready),
    .in_data(d32), .shift_op(shift_op), .shift_nos(n32), .out_valid(b_out_valid),
    .out_ready(out_ready), .aluout_sh(b_aluout), .carry(b_carry), .zero(b_zero), .op_err(b_op_err)
  );

  shift_unit_pipe #(.WIDTH(16), .PIPE_STAGES(2)) u_c (
    .clk2(clk2), .rst2(rst2), .en_sh(en_sh), .in_valid(iv16), .in_ready(c_in_ready),
    .in_data(d16), .shift_op(shift_op), .shift_nos(n16), .out_valid(c_out_valid),
    .out_ready(out_ready), .aluout_sh(c_aluout), .carry(c_carry), .zero(c_zero), .op_err(c_op_err)
  );

  always #5 clk2 = ~clk2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic v, input logic [31:0] r,
                         input logic c, input logic z, input logic e, input vec_t x);
    chk({tag, " valid"}, {31'b0, v}, 32'd1);
    chk({tag, " res"}, r, x.res);
    chk({tag, " carry"}, {31'b0, c}, {31'b0, x.c});
    chk({tag, " zero"}, {31'b0, z}, {31'b0, x.z});
    chk({tag, " op_err"}, {31'b0, e}, {31'b0, x.e});
  endtask

  // issue one op to both 32-bit units, hold the output, then drain
  task automatic run_vec32(input vec_t x, input int idx);
    shift_op = x.op; d32 = x.din; n32 = x.n; iv32 = 1'b1; out_ready = 1'b0;
    #1;
    chk($sformatf("v32[%0d] a in_ready", idx), {31'b0, a_in_ready}, 32'd1);
    chk($sformatf("v32[%0d] b in_ready", idx), {31'b0, b_in_ready}, 32'd1);
    @(negedge clk2);
    iv32 = 1'b0;
    chk($sformatf("v32[%0d] a lat1 valid", idx), {31'b0, a_out_valid}, 32'd0);
    chk_res($sformatf("v32[%0d] b", idx), b_out_valid, b_aluout, b_carry, b_zero, b_op_err, x);
    @(negedge clk2);
    chk_res($sformatf("v32[%0d] a", idx), a_out_valid, a_aluout, a_carry, a_zero, a_op_err, x);
    chk($sformatf("v32[%0d] b held", idx), b_aluout, x.res);
    out_ready = 1'b1;
    @(negedge clk2);
    chk($sformatf("v32[%0d] a drained", idx), {31'b0, a_out_valid}, 32'd0);
    chk($sformatf("v32[%0d] b drained", idx), {31'b0, b_out_valid}, 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic run_vec16(input vec_t x, input int idx);
    shift_op = x.op; d16 = x.din[15:0]; n16 = x.n[3:0]; iv16 = 1'b1; out_ready = 1'b0;
    #1;
    chk($sformatf("v16[%0d] in_ready", idx), {31'b0, c_in_ready}, 32'd1);
    @(negedge clk2);
    iv16 = 1'b0;
    chk($sformatf("v16[%0d] lat1 valid", idx), {31'b0, c_out_valid}, 32'd0);
    @(negedge clk2);
    chk_res($sformatf("v16[%0d]", idx), c_out_valid, {16'b0, c_aluout}, c_carry, c_zero, c_op_err, x);
    out_ready = 1'b1;
    @(negedge clk2);
    chk($sformatf("v16[%0d] drained", idx), {31'b0, c_out_valid}, 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    v32[0]  = '{3'b011, 5'd4,  32'h80000010, 32'hF8000001, 1'b0, 1'b0, 1'b0};
    v32[1]  = '{3'b000, 5'd1,  32'h80000001, 32'h00000002, 1'b1, 1'b0, 1'b0};
    v32[2]  = '{3'b101, 5'd1,  32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0};
    v32[3]  = '{3'b100, 5'd8,  32'h12345678, 32'h34567812, 1'b0, 1'b0, 1'b0};
    v32[4]  = '{3'b010, 5'd4,  32'h0000000F, 32'h00000000, 1'b1, 1'b1, 1'b0};
    v32[5]  = '{3'b000, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    v32[6]  = '{3'b001, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    v32[7]  = '{3'b010, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    v32[8]  = '{3'b011, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    v32[9]  = '{3'b100, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    v32[10] = '{3'b101, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    v32[11] = '{3'b110, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
    v32[12] = '{3'b001, 5'd2,  32'h40000001, 32'h00000004, 1'b1, 1'b0, 1'b0};
    v32[13] = '{3'b011, 5'd31, 32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b1, 1'b0};
    v32[14] = '{3'b011, 5'd31, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    v32[15] = '{3'b100, 5'd31, 32'h80000000, 32'h40000000, 1'b0, 1'b0, 1'b0};
    v32[16] = '{3'b101, 5'd31, 32'hC0000001, 32'h80000003, 1'b1, 1'b0, 1'b0};
    v32[17] = '{3'b111, 5'd31, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b1};
    v32[18] = '{3'b010, 5'd31, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 1'b0};

    v16[0] = '{3'b011, 5'd4,  32'h8010, 32'hF801, 1'b0, 1'b0, 1'b0};
    v16[1] = '{3'b000, 5'd1,  32'h8001, 32'h0002, 1'b1, 1'b0, 1'b0};
    v16[2] = '{3'b101, 5'd1,  32'h0001, 32'h8000, 1'b1, 1'b0, 1'b0};
    v16[3] = '{3'b100, 5'd8,  32'h1234, 32'h3412, 1'b0, 1'b0, 1'b0};
    v16[4] = '{3'b010, 5'd4,  32'h000F, 32'h0000, 1'b1, 1'b1, 1'b0};
    v16[5] = '{3'b100, 5'd0,  32'hBEEF, 32'hBEEF, 1'b0, 1'b0, 1'b0};
    v16[6] = '{3'b110, 5'd3,  32'hBEEF, 32'hBEEF, 1'b0, 1'b0, 1'b1};
    v16[7] = '{3'b011, 5'd15, 32'h8000, 32'hFFFF, 1'b0, 1'b0, 1'b0};
    v16[8] = '{3'b101, 5'd15, 32'hC001, 32'h8003, 1'b1, 1'b0, 1'b0};
    v16[9] = '{3'b000, 5'd15, 32'h0003, 32'h8000, 1'b1, 1'b0, 1'b0};

    repeat (2) @(negedge clk2);
    rst2 = 1'b0;
    chk("rst a valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst a res", a_aluout, 32'd0);
    chk("rst a flags", {29'b0, a_carry, a_zero, a_op_err}, 32'd0);
    chk("rst b valid", {31'b0, b_out_valid}, 32'd0);
    chk("rst b res", b_aluout, 32'd0);
    chk("rst c valid", {31'b0, c_out_valid}, 32'd0);
    chk("rst c res", {16'b0, c_aluout}, 32'd0);
    chk("rst c flags", {29'b0, c_carry, c_zero, c_op_err}, 32'd0);

    for (int i = 0; i < 19; i++) run_vec32(v32[i], i);
    for (int i = 0; i < 10; i++) run_vec16(v16[i], i);

    // backpressure: third op must wait, then enters on the first drain cycle
    out_ready = 1'b0;
    shift_op = 3'b000; d32 = 32'h80000001; n32 = 5'd1; iv32 = 1'b1;
    #1 chk("bp op1 in_ready", {31'b0, a_in_ready}, 32'd1);
    @(negedge clk2);
    shift_op = 3'b101; d32 = 32'h00000001; n32 = 5'd1;
    #1 chk("bp op2 in_ready", {31'b0, a_in_ready}, 32'd1);
    chk("bp b op2 in_ready", {31'b0, b_in_ready}, 32'd0);
    @(negedge clk2);
    shift_op = 3'b011; d32 = 32'h80000010; n32 = 5'd4;
    #1 chk("bp op3 in_ready", {31'b0, a_in_ready}, 32'd0);
    @(negedge clk2);
    chk("bp stall valid", {31'b0, a_out_valid}, 32'd1);
    chk("bp stall res", a_aluout, 32'h00000002);
    out_ready = 1'b1;
    #1 chk("bp drain in_ready", {31'b0, a_in_ready}, 32'd1);
    @(negedge clk2);
    iv32 = 1'b0;
    chk("bp r2 valid", {31'b0, a_out_valid}, 32'd1);
    chk("bp r2 res", a_aluout, 32'h80000000);
    chk("bp r2 carry", {31'b0, a_carry}, 32'd1);
    @(negedge clk2);
    chk("bp r3 valid", {31'b0, a_out_valid}, 32'd1);
    chk("bp r3 res", a_aluout, 32'hF8000001);
    @(negedge clk2);
    chk("bp empty", {31'b0, a_out_valid}, 32'd0);
    chk("bp b empty", {31'b0, b_out_valid}, 32'd0);

    // reset with two ops in flight
    out_ready = 1'b0;
    shift_op = 3'b000; d32 = 32'h80000001; n32 = 5'd1; iv32 = 1'b1;
    @(negedge clk2);
    shift_op = 3'b101; d32 = 32'h00000001; n32 = 5'd1;
    @(negedge clk2);
    iv32 = 1'b0;
    chk("fl pre valid", {31'b0, a_out_valid}, 32'd1);
    rst2 = 1'b1;
    @(negedge clk2);
    rst2 = 1'b0;
    chk("fl a valid", {31'b0, a_out_valid}, 32'd0);
    chk("fl a res", a_aluout, 32'd0);
    chk("fl a flags", {29'b0, a_carry, a_zero, a_op_err}, 32'd0);
    chk("fl b valid", {31'b0, b_out_valid}, 32'd0);
    chk("fl b res", b_aluout, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk2);
      chk($sformatf("fl stale a %0d", k), {31'b0, a_out_valid}, 32'd0);
      chk($sformatf("fl stale b %0d", k), {31'b0, b_out_valid}, 32'd0);
    end

    // en_sh low freezes both handshakes
    out_ready = 1'b0;
    shift_op = 3'b010; d32 = 32'h0000000F; n32 = 5'd4; iv32 = 1'b1;
    @(negedge clk2);
    iv32 = 1'b0;
    @(negedge clk2);
    en_sh = 1'b0; out_ready = 1'b1;
    shift_op = 3'b000; d32 = 32'h80000001; n32 = 5'd1; iv32 = 1'b1;
    #1 chk("en in_ready", {31'b0, a_in_ready}, 32'd0);
    @(negedge clk2);
    chk("en held valid", {31'b0, a_out_valid}, 32'd1);
    chk("en held res", a_aluout, 32'd0);
    chk("en held flags", {30'b0, a_carry, a_zero}, 32'd3);
    chk("en b held valid", {31'b0, b_out_valid}, 32'd1);
    iv32 = 1'b0; en_sh = 1'b1;
    @(negedge clk2);
    chk("en drained", {31'b0, a_out_valid}, 32'd0);
    chk("en b drained", {31'b0, b_out_valid}, 32'd0);
    @(negedge clk2);
    chk("en no extra", {31'b0, a_out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
